pic_fetch_sequencer: RTL and testbench

// Program-counter and fetch sequencer for the 14-bit-opcode core. Owns the 13-bit PC,

---
 rtl/pic_fetch_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_pic_fetch_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_fetch_sequencer.sv
// Program-counter, instruction register and hardware return stack for the 14-bit-opcode core.
// Resolves GOTO/CALL/RET*, PCL writes, skips and interrupt entry with a one-cycle flush bubble.
module pic_fetch_sequencer #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter logic [12:0] RST_VECTOR  = 13'h000,
  parameter logic [12:0] IRQ_VECTOR  = 13'h004
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic [13:0] prog_dat_i,
  input  logic        skip_i,
  input  logic        pcl_wr_i,
  input  logic [7:0]  pcl_dat_i,
  input  logic [4:0]  pclath_i,
  input  logic        irq_i,
  output logic [12:0] prog_adr_o,
  output logic [13:0] inst_o,
  output logic        inst_valid_o,
  output logic        irq_ack_o,
  output logic        gie_set_o,
  output logic        stack_ovf_o,
  output logic        stack_unf_o
);

  localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W:0] DEPTH_FULL = (SP_W + 1)'(STACK_DEPTH);

  typedef enum logic [2:0] {
    EV_SEQ,
    EV_GOTO,
    EV_CALL,
    EV_RET,
    EV_PCL,
    EV_SKIP,
    EV_IRQ
  } pc_event_e;

  logic [12:0]     r_pc;
  logic [13:0]     r_inst;
  logic            r_valid;
  logic            r_irqAck;
  logic            r_gieSet;
  logic            r_ovf;
  logic            r_unf;
  logic [SP_W-1:0] r_sp;
  logic [SP_W:0]   r_depth;
  logic [12:0]     r_stack [STACK_DEPTH];

  logic            w_isGoto;
  logic            w_isCall;
  logic            w_isReturn;
  logic            w_isRetfie;
  logic            w_isRetlw;
  logic            w_isRet;
  logic [12:0]     w_target;
  logic [12:0]     w_pcInc;
  logic [SP_W-1:0] w_popIdx;
  logic [12:0]     w_popVal;
  pc_event_e       w_event;
  logic [12:0]     w_pcNext;
  logic            w_validNext;
  logic            w_push;
  logic            w_pop;
  logic            w_irqAckNext;
  logic            w_gieSetNext;
  logic [SP_W:0]   w_depthNext;

  // A flushed bubble carries a real ROM word, so every decode is qualified by r_valid.
  assign w_isGoto   = r_valid && (r_inst[13:11] == 3'b101);
  assign w_isCall   = r_valid && (r_inst[13:11] == 3'b100);
  assign w_isReturn = r_valid && (r_inst == 14'h0008);
  assign w_isRetfie = r_valid && (r_inst == 14'h0009);
  assign w_isRetlw  = r_valid && (r_inst[13:10] == 4'b1101);
  assign w_isRet    = w_isReturn || w_isRetfie || w_isRetlw;

  assign w_target = {pclath_i[4:3], r_inst[10:0]};
  assign w_pcInc  = r_pc + 13'd1;
  assign w_popIdx = r_sp - SP_W'(1);
  assign w_popVal = r_stack[w_popIdx];

  always_comb begin
    w_event = EV_SEQ;
    if (w_isGoto) begin
      w_event = EV_GOTO;
    end else if (w_isCall) begin
      w_event = EV_CALL;
    end else if (w_isRet) begin
      w_event = EV_RET;
    end else if (r_valid && pcl_wr_i) begin
      w_event = EV_PCL;
    end else if (r_valid && skip_i) begin
      w_event = EV_SKIP;
    end else if (r_valid && irq_i) begin
      w_event = EV_IRQ;
    end
  end

  always_comb begin
    w_pcNext     = w_pcInc;
    w_validNext  = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_irqAckNext = 1'b0;
    w_gieSetNext = 1'b0;
    case (w_event)
      EV_SEQ: begin
        w_validNext = 1'b1;
      end
      EV_GOTO: begin
        w_pcNext = w_target;
      end
      EV_CALL: begin
        w_pcNext = w_target;
        w_push   = 1'b1;
      end
      EV_RET: begin
        w_pcNext     = w_popVal;
        w_pop        = 1'b1;
        w_gieSetNext = w_isRetfie;
      end
      EV_PCL: begin
        w_pcNext = {pclath_i, pcl_dat_i};
      end
      EV_SKIP: begin
        w_pcNext = w_pcInc;
      end
      EV_IRQ: begin
        w_pcNext     = IRQ_VECTOR;
        w_push       = 1'b1;
        w_irqAckNext = 1'b1;
      end
      default: begin
        w_pcNext = w_pcInc;
      end
    endcase
  end

  // Depth saturates at both ends; the circular pointer keeps wrapping regardless.
  always_comb begin
    w_depthNext = r_depth;
    if (w_push && (r_depth != DEPTH_FULL)) begin
      w_depthNext = r_depth + (SP_W + 1)'(1);
    end else if (w_pop && (r_depth != '0)) begin
      w_depthNext = r_depth - (SP_W + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc     <= RST_VECTOR;
      r_inst   <= '0;
      r_valid  <= 1'b0;
      r_irqAck <= 1'b0;
      r_gieSet <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_sp     <= '0;
      r_depth  <= '0;
    end else if (stall_i) begin
      r_irqAck <= 1'b0;
      r_gieSet <= 1'b0;
    end else begin
      r_pc     <= w_pcNext;
      r_inst   <= prog_dat_i;
      r_valid  <= w_validNext;
      r_irqAck <= w_irqAckNext;
      r_gieSet <= w_gieSetNext;
      r_depth  <= w_depthNext;
      if (w_push) begin
        r_sp <= r_sp + SP_W'(1);
        if (r_depth == DEPTH_FULL) begin
          r_ovf <= 1'b1;
        end
      end else if (w_pop) begin
        r_sp <= w_popIdx;
        if (r_depth == '0) begin
          r_unf <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !stall_i && w_push) begin
      r_stack[r_sp] <= r_pc;
    end
  end

  assign prog_adr_o   = r_pc;
  assign inst_o       = r_inst;
  assign inst_valid_o = r_valid;
  assign irq_ack_o    = r_irqAck;
  assign gie_set_o    = r_gieSet;
  assign stack_ovf_o  = r_ovf;
  assign stack_unf_o  = r_unf;

endmodule

// File: tb/tb_pic_fetch_sequencer.sv
// Directed bench for pic_fetch_sequencer: async ROM model, one task per scenario,
// inline comparisons against hand-computed addresses and flags.
module tb_pic_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic [13:0] prog_dat_i;
  logic        skip_i;
  logic        pcl_wr_i;
  logic [7:0]  pcl_dat_i;
  logic [4:0]  pclath_i;
  logic        irq_i;
  logic [12:0] prog_adr_o;
  logic [13:0] inst_o;
  logic        inst_valid_o;
  logic        irq_ack_o;
  logic        gie_set_o;
  logic        stack_ovf_o;
  logic        stack_unf_o;

  logic [13:0] rom [8192];
  int total = 0;
  int bad   = 0;

  pic_fetch_sequencer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .prog_dat_i   (prog_dat_i),
    .skip_i       (skip_i),
    .pcl_wr_i     (pcl_wr_i),
    .pcl_dat_i    (pcl_dat_i),
    .pclath_i     (pclath_i),
    .irq_i        (irq_i),
    .prog_adr_o   (prog_adr_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .irq_ack_o    (irq_ack_o),
    .gie_set_o    (gie_set_o),
    .stack_ovf_o  (stack_ovf_o),
    .stack_unf_o  (stack_unf_o)
  );

  assign prog_dat_i = rom[prog_adr_o];

  always #5 clk_i = ~clk_i;

  // Outputs are sampled and inputs changed 1ns after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 8192; i++) rom[i] = 14'h0000;
  endtask

  task automatic applyStimulus(input logic skip, input logic pclWr, input logic [7:0] pclDat,
                               input logic [4:0] pclath, input logic irq, input logic stall);
    skip_i    = skip;
    pcl_wr_i  = pclWr;
    pcl_dat_i = pclDat;
    pclath_i  = pclath;
    irq_i     = irq;
    stall_i   = stall;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00, 1'b0, 1'b0);
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    clearRom();
    rom[0] = 14'h0100;
    rom[1] = 14'h0101;
    rom[2] = 14'h0102;
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00, 1'b1, 1'b1);
    rst_i = 1'b1;
    tick();
    tick();
    total++;
    if (prog_adr_o !== 13'h000) begin
      bad++; $display("[TB] FAIL reset_adr got=%h exp=%h", prog_adr_o, 13'h000);
    end
    total++;
    if ({inst_valid_o, inst_o} !== 15'h0000) begin
      bad++; $display("[TB] FAIL reset_inst got=%b_%h exp=0_0000", inst_valid_o, inst_o);
    end
    total++;
    if ({irq_ack_o, gie_set_o, stack_ovf_o, stack_unf_o} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_flags got=%b exp=0000",
                      {irq_ack_o, gie_set_o, stack_ovf_o, stack_unf_o});
    end
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (prog_adr_o !== 13'(i)) begin
        bad++; $display("[TB] FAIL linear_adr%0d got=%h exp=%h", i, prog_adr_o, 13'(i));
      end
      total++;
      if (inst_valid_o !== 1'b1 || inst_o !== 14'h0100 + 14'(i - 1)) begin
        bad++; $display("[TB] FAIL linear_inst%0d got=%b_%h exp=1_%h", i, inst_valid_o, inst_o,
                        14'h0100 + 14'(i - 1));
      end
    end
  endtask

  task automatic test_goto();
    clearRom();
    rom[0]       = 14'h2805;
    rom[13'h1805] = 14'h0123;
    doReset();
    pclath_i = 5'h18;
    tick();
    total++;
    if (inst_o !== 14'h2805 || inst_valid_o !== 1'b1) begin
      bad++; $display("[TB] FAIL goto_fetch got=%b_%h exp=1_2805", inst_valid_o, inst_o);
    end
    tick();
    total++;
    if (prog_adr_o !== 13'h1805 || inst_valid_o !== 1'b0) begin
      bad++; $display("[TB] FAIL goto_target got=%h/v%b exp=1805/v0", prog_adr_o, inst_valid_o);
    end
    tick();
    total++;
    if (prog_adr_o !== 13'h1806 || inst_valid_o !== 1'b1 || inst_o !== 14'h0123) begin
      bad++; $display("[TB] FAIL goto_resume got=%h/v%b/%h exp=1806/v1/0123",
                      prog_adr_o, inst_valid_o, inst_o);
    end
  endtask

  task automatic test_pc_wrap();
    clearRom();
    rom[0]        = 14'h2FFF;
    rom[13'h1FFF] = 14'h0ABC;
    doReset();
    pclath_i = 5'h18;
    tick();
    tick();
    total++;
    if (prog_adr_o !== 13'h1FFF) begin
      bad++; $display("[TB] FAIL wrap_top got=%h exp=1fff", prog_adr_o);
    end
    tick();
    total++;
    if (prog_adr_o !== 13'h0000 || inst_o !== 14'h0ABC || inst_valid_o !== 1'b1) begin
      bad++; $display("[TB] FAIL wrap_zero got=%h/%h/v%b exp=0000/0abc/v1",
                      prog_adr_o, inst_o, inst_valid_o);
    end
  endtask

  task automatic test_priority();
    clearRom();
    rom[0] = 14'h2840;
    doReset();
    tick();
    applyStimulus(1'b1, 1'b1, 8'h77, 5'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00, 1'b0, 1'b0);
    total++;
    if (prog_adr_o !== 13'h0040 || irq_ack_o !== 1'b0) begin
      bad++; $display("[TB] FAIL prio_goto got=%h/ack%b exp=0040/ack0", prog_adr_o, irq_ack_o);
    end
  endtask

  task automatic test_call_return();
    clearRom();
    rom[0]      = 14'h2810;
    rom[13'h010] = 14'h2100;
    rom[13'h100] = 14'h0008;
    doReset();
    tick();
    tick();
    tick();
    tick();
    total++;
    if (prog_adr_o !== 13'h0100 || inst_valid_o !== 1'b0) begin
      bad++; $display("[TB] FAIL call_target got=%h/v%b exp=0100/v0", prog_adr_o, inst_valid_o);
    end
    tick();
    tick();
    total++;
    if (prog_adr_o !== 13'h0011) begin
      bad++; $display("[TB] FAIL return_addr got=%h exp=0011", prog_adr_o);
    end
    tick();
    total++;
    if (prog_adr_o !== 13'h0012 || inst_valid_o !== 1'b1) begin
      bad++; $display("[TB] FAIL return_resume got=%h/v%b exp=0012/v1", prog_adr_o, inst_valid_o);
    end
    total++;
    if ({stack_ovf_o, stack_unf_o} !== 2'b00) begin
      bad++; $display("[TB] FAIL call_flags got=%b exp=00", {stack_ovf_o, stack_unf_o});
    end
  endtask

  task automatic test_retlw();
    clearRom();
    rom[0]       = 14'h2300;
    rom[13'h300] = 14'h3455;
    doReset();
    tick();
    tick();
    tick();
    tick();
    total++;
    if (prog_adr_o !== 13'h0001 || inst_valid_o !== 1'b0) begin
      bad++; $display("[TB] FAIL retlw_addr got=%h/v%b exp=0001/v0", prog_adr_o, inst_valid_o);
    end
  endtask

  task automatic test_pcl_write();
    clearRom();
    doReset();
    tick();
    applyStimulus(1'b0, 1'b1, 8'h34, 5'h05, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00, 1'b0, 1'b0);
    total++;
    if (prog_adr_o !== 13'h0534 || inst_valid_o !== 1'b0) begin
      bad++; $display("[TB] FAIL pcl_target got=%h/v%b exp=0534/v0", prog_adr_o, inst_valid_o);
    end
    tick();
    total++;
    if (prog_adr_o !== 13'h0535 || inst_valid_o !== 1'b1) begin
      bad++; $display("[TB] FAIL pcl_resume got=%h/v%b exp=0535/v1", prog_adr_o, inst_valid_o);
    end
  endtask

  task automatic test_skip();
    clearRom();
    rom[0]       = 14'h2820;
    rom[13'h021] = 14'h0111;
    rom[13'h022] = 14'h0222;
    doReset();
    tick();
    tick();
    tick();
    skip_i = 1'b1;
    tick();
    skip_i = 1'b0;
    total++;
    if (prog_adr_o !== 13'h0022 || inst_valid_o !== 1'b0 || inst_o !== 14'h0111) begin
      bad++; $display("[TB] FAIL skip_bubble got=%h/v%b/%h exp=0022/v0/0111",
                      prog_adr_o, inst_valid_o, inst_o);
    end
    tick();
    total++;
    if (prog_adr_o !== 13'h0023 || inst_valid_o !== 1'b1 || inst_o !== 14'h0222) begin
      bad++; $display("[TB] FAIL skip_next got=%h/v%b/%h exp=0023/v1/0222",
                      prog_adr_o, inst_valid_o, inst_o);
    end
  endtask

  task automatic test_irq_retfie_stall();
    clearRom();
    rom[0]       = 14'h2850;
    rom[13'h004] = 14'h0009;
    rom[13'h051] = 14'h0155;
    doReset();
    tick();
    tick();
    tick();
    irq_i = 1'b1;
    tick();
    irq_i = 1'b0;
    total++;
    if (prog_adr_o !== 13'h0004 || irq_ack_o !== 1'b1 || inst_valid_o !== 1'b0) begin
      bad++; $display("[TB] FAIL irq_entry got=%h/ack%b/v%b exp=0004/ack1/v0",
                      prog_adr_o, irq_ack_o, inst_valid_o);
    end
    tick();
    total++;
    if (prog_adr_o !== 13'h0005 || irq_ack_o !== 1'b0 || inst_o !== 14'h0009) begin
      bad++; $display("[TB] FAIL irq_fetch_retfie got=%h/ack%b/%h exp=0005/ack0/0009",
                      prog_adr_o, irq_ack_o, inst_o);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (prog_adr_o !== 13'h0005 || inst_o !== 14'h0009 || inst_valid_o !== 1'b1 ||
          irq_ack_o !== 1'b0 || gie_set_o !== 1'b0) begin
        bad++; $display("[TB] FAIL stall_hold%0d got=%h/%h/v%b/ack%b/gie%b exp=0005/0009/v1/ack0/gie0",
                        i, prog_adr_o, inst_o, inst_valid_o, irq_ack_o, gie_set_o);
      end
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00, 1'b0, 1'b0);
    tick();
    total++;
    if (prog_adr_o !== 13'h0051 || gie_set_o !== 1'b1 || inst_valid_o !== 1'b0) begin
      bad++; $display("[TB] FAIL retfie_return got=%h/gie%b/v%b exp=0051/gie1/v0",
                      prog_adr_o, gie_set_o, inst_valid_o);
    end
    tick();
    total++;
    if (prog_adr_o !== 13'h0052 || gie_set_o !== 1'b0 || inst_o !== 14'h0155) begin
      bad++; $display("[TB] FAIL retfie_resume got=%h/gie%b/%h exp=0052/gie0/0155",
                      prog_adr_o, gie_set_o, inst_o);
    end
  endtask

  task automatic test_nested_overflow();
    logic [12:0] retExp [9];
    retExp = '{13'h271, 13'h261, 13'h251, 13'h241, 13'h231, 13'h221, 13'h211, 13'h201, 13'h271};
    clearRom();
    rom[0]       = 14'h2200;
    rom[13'h280] = 14'h0008;
    for (int k = 1; k <= 8; k++) begin
      rom[13'h200 + 13'((k - 1) * 16)] = 14'h2200 + 14'(k * 16);
      rom[13'h201 + 13'((k - 1) * 16)] = 14'h0008;
    end
    doReset();
    for (int k = 1; k <= 9; k++) begin
      tick();
      tick();
      total++;
      if (prog_adr_o !== 13'h200 + 13'((k - 1) * 16)) begin
        bad++; $display("[TB] FAIL call%0d_target got=%h exp=%h", k, prog_adr_o,
                        13'h200 + 13'((k - 1) * 16));
      end
      if (k >= 8) begin
        total++;
        if (stack_ovf_o !== (k == 9)) begin
          bad++; $display("[TB] FAIL call%0d_ovf got=%b exp=%b", k, stack_ovf_o, (k == 9));
        end
      end
    end
    for (int j = 1; j <= 9; j++) begin
      tick();
      tick();
      total++;
      if (prog_adr_o !== retExp[j - 1]) begin
        bad++; $display("[TB] FAIL ret%0d_addr got=%h exp=%h", j, prog_adr_o, retExp[j - 1]);
      end
      if (j >= 8) begin
        total++;
        if (stack_unf_o !== (j == 9)) begin
          bad++; $display("[TB] FAIL ret%0d_unf got=%b exp=%b", j, stack_unf_o, (j == 9));
        end
      end
    end
  endtask

  task automatic test_reset_override();
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00, 1'b1, 1'b1);
    rst_i = 1'b1;
    tick();
    total++;
    if (prog_adr_o !== 13'h0000 || inst_valid_o !== 1'b0 ||
        {stack_ovf_o, stack_unf_o} !== 2'b00) begin
      bad++; $display("[TB] FAIL rst_override got=%h/v%b/flags%b exp=0000/v0/flags00",
                      prog_adr_o, inst_valid_o, {stack_ovf_o, stack_unf_o});
    end
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00, 1'b0, 1'b0);
    tick();
    total++;
    if (prog_adr_o !== 13'h0001 || inst_valid_o !== 1'b1) begin
      bad++; $display("[TB] FAIL rst_first_fetch got=%h/v%b exp=0001/v1", prog_adr_o, inst_valid_o);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00, 1'b0, 1'b0);
    test_reset();
    test_goto();
    test_pc_wrap();
    test_priority();
    test_call_return();
    test_retlw();
    test_pcl_write();
    test_skip();
    test_irq_retfie_stall();
    test_nested_overflow();
    test_reset_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
